// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 program RAM, IR, A, B and adder/subtractor,
// driven each cycle by the controller's 12-bit control word over a single bus.
module sap1_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] a_out,
  output logic              carry,
  output logic              zero,
  output logic              halted,
  output logic              bus_conflict
);

  logic hlt, pc_inc, pc_en, mem_load, mem_en, ir_load, ir_en;
  logic a_load, a_en, b_load, adder_sub, adder_en;

  assign hlt       = ctrl[11];
  assign pc_inc    = ctrl[10];
  assign pc_en     = ctrl[9];
  assign mem_load  = ctrl[8];
  assign mem_en    = ctrl[7];
  assign ir_load   = ctrl[6];
  assign ir_en     = ctrl[5];
  assign a_load    = ctrl[4];
  assign a_en      = ctrl[3];
  assign b_load    = ctrl[2];
  assign adder_sub = ctrl[1];
  assign adder_en  = ctrl[0];

  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic              carry_q, carry_d, zero_q, zero_d;
  logic              halted_q, halted_d, conflict_q, conflict_d;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic [DATA_W:0]   add_full;
  logic [DATA_W-1:0] sum;
  logic              sum_cout;
  logic              multi_drv;

  always_comb begin
    add_full = {1'b0, a_q} + {1'b0, b_q};
    if (adder_sub) begin
      sum      = a_q - b_q;
      sum_cout = (a_q < b_q);
    end else begin
      sum      = add_full[DATA_W-1:0];
      sum_cout = add_full[DATA_W];
    end
  end

  assign multi_drv = ($countones({pc_en, mem_en, ir_en, a_en, adder_en}) > 1);

  // Contention forces the bus to zero rather than resolving a winner.
  always_comb begin
    bus = '0;
    if (!multi_drv) begin
      if (pc_en)    bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      if (mem_en)   bus = mem_q[mar_q];
      if (ir_en)    bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
      if (a_en)     bus = a_q;
      if (adder_en) bus = sum;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    mar_d      = mar_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    halted_d   = halted_q | hlt;
    conflict_d = conflict_q | multi_drv;
    // Loads issued alongside HLT still land; only later words are frozen.
    if (!halted_q) begin
      if (mem_load) mar_d = bus[ADDR_W-1:0];
      if (ir_load)  ir_d  = bus;
      if (a_load)   a_d   = bus;
      if (b_load)   b_d   = bus;
      if (pc_inc)   pc_d  = pc_q + 1'b1;
      if (a_load && adder_en) begin
        carry_d = sum_cout;
        zero_d  = (sum == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      halted_q   <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      halted_q   <= halted_d;
      conflict_q <= conflict_d;
    end
  end

  // Program port is independent of reset and halt.
  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end

  assign opcode       = ir_q[DATA_W-1 -: 4];
  assign a_out        = a_q;
  assign carry        = carry_q;
  assign zero         = zero_q;
  assign halted       = halted_q;
  assign bus_conflict = conflict_q;

endmodule

// File: doc/sap1_datapath.md
Name: sap1_datapath

Overview:
- Executing end of the SAP-1 control-word interface. It consumes the 12-bit control word each cycle and performs the bus transfers it names.
- Owns PC, MAR, 16x8 RAM, IR, A, B and the adder/subtractor, and returns the opcode to the controller.
- Sits between the controller and the top level. A program-load port fills RAM before or after a run.

Parameters:
- DATA_W, 8, bus/register/RAM word width
- ADDR_W, 4, PC/MAR/RAM address width (RAM depth 2**ADDR_W)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ctrl  in  12  control word: [11]HLT [10]PC_INC [9]PC_EN [8]MEM_LOAD(MAR load) [7]MEM_EN [6]IR_LOAD [5]IR_EN [4]A_LOAD [3]A_EN [2]B_LOAD [1]ADDER_SUB [0]ADDER_EN
- prog_we  in  1  RAM program write strobe
- prog_addr  in  ADDR_W  program write address
- prog_data  in  DATA_W  program write data
- opcode  out  4  IR[7:4], to controller
- bus  out  DATA_W  current bus value (combinational)
- a_out  out  DATA_W  accumulator A
- carry  out  1  carry/borrow flag
- zero  out  1  zero flag
- halted  out  1  sticky halt
- bus_conflict  out  1  sticky multi-driver error

Behaviour:
- Reset values:
  - pc, mar, ir, a, b all 0.
  - carry, zero, halted, bus_conflict all 0.
  - RAM contents are not cleared by reset.
- Bus drivers (combinational, same cycle):
  - PC_EN drives {0, pc}.
  - MEM_EN drives ram[mar].
  - IR_EN drives {0, ir[3:0]}.
  - A_EN drives a.
  - ADDER_EN drives sum.
  - No driver: bus = 0.
- Multiple drivers:
  - If two or more of PC_EN, MEM_EN, IR_EN, A_EN, ADDER_EN are set, bus = 0 and bus_conflict sets at the next edge. It stays set until rst.
  - Loads in that cycle still occur and capture 0.
- Adder arithmetic:
  - ADDER_SUB=0: sum = a + b, truncated to DATA_W.
  - ADDER_SUB=1: sum = a - b, two's complement, truncated.
- Loads (rising edge, when not halted):
  - MEM_LOAD: mar <= bus[ADDR_W-1:0].
  - IR_LOAD: ir <= bus.
  - A_LOAD: a <= bus.
  - B_LOAD: b <= bus.
  - PC_INC: pc <= pc+1, wrapping 15 -> 0.
  - Zero latency: each load uses the bus value of the same cycle.
- Flags update only on a cycle with A_LOAD && ADDER_EN:
  - carry = carry-out of the add, or borrow (a < b unsigned) on subtract.
  - zero = (sum == 0).
  - A_LOAD from any other source leaves the flags unchanged.
- Simultaneous PC_EN and PC_INC: bus shows the old pc; pc increments.
- Halt:
  - HLT set in any cycle sets halted at that edge.
  - Loads or PC_INC issued in the same cycle as HLT are still performed.
  - Once halted, every later control word's loads and PC_INC are ignored. Bus and bus_conflict are still driven and evaluated.
  - Only rst clears halted.
- RAM:
  - Asynchronous read, synchronous write.
  - prog_we writes ram[prog_addr] <= prog_data at the edge, accepted whether halted or not, and also during rst.
  - A MEM_EN read of the address being written in the same cycle returns the old data.
- Reset mid-operation: rst has priority over all loads in that cycle. prog_we is still honoured.
- opcode = ir[7:4] at all times. It is registered state with no extra pipeline; the controller's one-cycle output register provides the latency.

Test Plan:
- Full program run:
  - Stimulus: preload RAM 0:0x09 1:0x1A 2:0x2B 3:0xF0, 9:5 10:7 11:3; drive the 6-stage control sequence per instruction.
  - Required: after LDA a=5; after ADD a=12, carry=0; after SUB a=9, carry=0, zero=0; at the HLT stage halted=1, pc=4; later words leave a=9.
- Add overflow:
  - Stimulus: a=0xF0, b=0x10, ctrl ADDER_EN|A_LOAD.
  - Required: a=0x00, carry=1, zero=1.
- Subtract borrow:
  - Stimulus: a=3, b=5, ADDER_SUB|ADDER_EN|A_LOAD.
  - Required: a=0xFE, carry=1, zero=0.
- PC wrap and overlap:
  - Stimulus: pc=15; ctrl PC_EN|PC_INC|MEM_LOAD.
  - Required: bus=0x0F that cycle, mar=15, pc=0 next cycle.
- Bus conflict:
  - Stimulus: ctrl PC_EN|A_EN|B_LOAD.
  - Required: bus=0, b=0, bus_conflict=1 and stays 1 for 10 idle cycles; rst clears it.
- Halt and reset:
  - Stimulus: HLT then A_LOAD with MEM_EN.
  - Required: a unchanged; prog_we while halted updates RAM; rst clears halted and pc while RAM keeps its contents.
